one_hot_to_bin_stream: RTL
==========================

Name: one_hot_to_bin_stream

Overview:
- Pipelined, handshaked decoder from a ONE_HOT_W-bit one-hot vector back to a BIN_W-bit binary index. It is the return path of the binary-to-one-hot converter.
- Validates every input: zero-hot and multi-hot words are flagged, and a saturating error counter records them.
- Sits between a one-hot arbiter/grant source and binary-indexed consumers such as mux selects and address fields.

Parameters:
- BIN_W, 4, binary index width.
- ONE_HOT_W, 16, one-hot input width; must equal 2**BIN_W, checked at elaboration with $error.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_valid_i  input  1  one_hot_i is valid this cycle
- in_ready_o  output  1  block can accept a word this cycle
- one_hot_i  input  ONE_HOT_W  one-hot input vector
- out_valid_o  output  1  bin_o/err_o valid
- out_ready_i  input  1  downstream accepts output
- bin_o  output  BIN_W  decoded index
- err_o  output  1  word was zero-hot or multi-hot
- err_cnt_o  output  ERR_CNT_W  saturating count of error words accepted at output
- err_cnt_clr_i  input  1  synchronous clear of err_cnt_o

Behaviour:
- Single clock domain with synchronous active-high reset. All state updates on posedge clk.
- Reset values: out_valid_o=0, bin_o=0, err_o=0, err_cnt_o=0, both stage valids=0. in_ready_o=1 in the cycle after reset deasserts.
- Reset mid-operation discards every in-flight word. No output handshake occurs for discarded words.
- Stage 1 (capture):
  - Registers one_hot_i when in_valid_i && in_ready_o.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready_o = s1_ready.
- Stage 2 (encode):
  - Registers the encoder result of the stage-1 word when s1_valid && s2_ready.
  - s2_ready = !out_valid_o || out_ready_i.
- Latency and throughput:
  - 2 cycles from input handshake to out_valid_o, with no stalls.
  - Full throughput of 1 word/cycle when out_ready_i is held high.
- Backpressure:
  - While out_valid_o && !out_ready_i, bin_o and err_o hold stable.
  - Both stages fill, after which in_ready_o=0. No word is lost or duplicated.
- Encoding rules:
  - Exactly one bit k set: bin=k, err=0.
  - Zero bits set: bin=0, err=1.
  - Two or more bits set: bin=lowest set index, err=1.
- Error counter:
  - Increments by 1 on each output handshake (out_valid_o && out_ready_i) with err_o=1.
  - Saturates at 2**ERR_CNT_W-1; no wrap.
  - err_cnt_clr_i has priority. When clear coincides with an error handshake, the result is 0 and the event is not counted.
- Simultaneous input and output handshakes in the same cycle are legal. Pipeline occupancy stays constant.
- Unused-width safety: the encoder loop covers exactly ONE_HOT_W bits.

Decomposition:
- Package one_hot_pkg:
  - Default constants BIN_W_DEF=4, ONE_HOT_W_DEF=16.
  - Function popcount_gt1 (multi-hot detect), shared with future arbiter blocks.
- One sub-module: one_hot_to_bin_enc.
  - Combinational, parameterised by BIN_W/ONE_HOT_W.
  - Inputs: one_hot. Outputs: bin and err.
  - Instantiated once between stage 1 and stage 2.

Test Plan:
- Reset, then drive the 16 words 16'h0001<<k (k=0..15) back-to-back with out_ready_i=1:
  - Outputs bin_o=0..15 in order, err_o=0.
  - First out_valid_o 2 cycles after the first accept; one output per cycle; err_cnt_o=0.
- Invalid words:
  - one_hot_i=16'h0000 -> bin_o=0, err_o=1.
  - 16'h0120 -> bin_o=5, err_o=1.
  - 16'h8001 -> bin_o=0, err_o=1.
  - err_cnt_o=3 afterwards.
- Backpressure:
  - Stream words 16'h0004, 16'h0040, 16'h0400 with out_ready_i=0 -> in_ready_o drops to 0 after 2 accepts, bin_o holds 2.
  - Release out_ready_i -> outputs 2, 6, 10 with no loss or duplication.
- Saturation, with ERR_CNT_W=2:
  - 5 error words -> err_cnt_o sticks at 3.
  - err_cnt_clr_i pulsed with a simultaneous error handshake -> err_cnt_o=0.
- Reset mid-stream:
  - Assert reset with 2 words in flight -> next cycle out_valid_o=0, no spurious output.
  - Then 16'h0800 -> bin_o=11 after 2 cycles.
- Random valid/ready toggling on 1000 random words:
  - Scoreboard compares against a reference model (index, lowest-set-bit and error rules).
  - Order is preserved and the error count matches.

Source files
------------

// File: rtl/one_hot_pkg.sv
// Purpose : shared constants and helpers for one-hot encode/decode blocks.
// Latency : n/a (types, constants and combinational helper functions only).
// Backpressure : n/a.
package one_hot_pkg;

   localparam int BIN_W_DEF       = 4;
   localparam int ONE_HOT_W_DEF   = 16;
   // Widest one-hot vector the shared helper below can inspect.
   localparam int ONE_HOT_W_MAX   = 64;

   // Multi-hot detect: clearing the lowest set bit leaves something only when
   // two or more bits were set. Callers zero-extend narrower vectors.
   function automatic logic popcount_gt1(input logic [ONE_HOT_W_MAX-1:0] v);
      logic [ONE_HOT_W_MAX-1:0] one;
      one = {{(ONE_HOT_W_MAX-1){1'b0}}, 1'b1};
      return |(v & (v - one));
   endfunction

endpackage

// File: rtl/one_hot_to_bin_enc.sv
// Purpose : combinational one-hot to binary encoder with zero/multi-hot flag.
// Latency : 0 cycles (pure combinational).
// Backpressure : none; no state.
// Ports   : one_hot (ONE_HOT_W in) -> bin (lowest set index, 0 if none),
//           err (set when the word is not exactly one-hot).
module one_hot_to_bin_enc
   import one_hot_pkg::*;
#(
   parameter int BIN_W     = BIN_W_DEF,
   parameter int ONE_HOT_W = ONE_HOT_W_DEF
) (
   input  logic [ONE_HOT_W-1:0] one_hot,
   output logic [BIN_W-1:0]     bin,
   output logic                 err
);

   if (ONE_HOT_W > ONE_HOT_W_MAX) begin : g_too_wide
      $error("one_hot_to_bin_enc: ONE_HOT_W exceeds ONE_HOT_W_MAX");
   end

   logic [ONE_HOT_W_MAX-1:0] oh_ext;

   always_comb begin
      oh_ext = '0;
      oh_ext[ONE_HOT_W-1:0] = one_hot;
   end

   // Scan from the top down so the last hit written is the lowest set bit,
   // which is the index reported for multi-hot words.
   always_comb begin
      bin = '0;
      for (int k = ONE_HOT_W - 1; k >= 0; k--) begin
         if (one_hot[k]) begin
            bin = BIN_W'(k);
         end
      end
   end

   assign err = ~(|one_hot) | popcount_gt1(oh_ext);

endmodule

// File: rtl/one_hot_to_bin_stream.sv
// Purpose : two-stage valid/ready decoder from one-hot word to binary index,
//           flagging zero/multi-hot words and counting them (saturating).
// Latency : 2 cycles input handshake -> out_valid_o; 1 word/cycle throughput.
// Backpressure : out_ready_i low holds bin_o/err_o; both stages fill, then in_ready_o drops.
// Ports   : clk/reset (sync, active high); in_valid_i/in_ready_o/one_hot_i input side;
//           out_valid_o/out_ready_i/bin_o/err_o output side; err_cnt_o counter with
//           err_cnt_clr_i synchronous clear.
module one_hot_to_bin_stream
   import one_hot_pkg::*;
#(
   parameter int BIN_W     = BIN_W_DEF,
   parameter int ONE_HOT_W = ONE_HOT_W_DEF,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [ONE_HOT_W-1:0] one_hot_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [BIN_W-1:0]     bin_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o,
   input  logic                 err_cnt_clr_i
);

   if (ONE_HOT_W != (1 << BIN_W)) begin : g_bad_width
      $error("one_hot_to_bin_stream: ONE_HOT_W must equal 2**BIN_W");
   end

   logic                 s1_valid;
   logic [ONE_HOT_W-1:0] s1_data;
   logic                 s1_ready;
   logic                 s2_ready;
   logic [BIN_W-1:0]     enc_bin;
   logic                 enc_err;
   logic                 err_evt;

   assign s2_ready   = !out_valid_o || out_ready_i;
   assign s1_ready   = !s1_valid || s2_ready;
   assign in_ready_o = s1_ready;
   assign err_evt    = out_valid_o && out_ready_i && err_o;

   one_hot_to_bin_enc #(
      .BIN_W     (BIN_W),
      .ONE_HOT_W (ONE_HOT_W)
   ) u_enc (
      .one_hot (s1_data),
      .bin     (enc_bin),
      .err     (enc_err)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid    <= 1'b0;
         s1_data     <= '0;
         out_valid_o <= 1'b0;
         bin_o       <= '0;
         err_o       <= 1'b0;
         err_cnt_o   <= '0;
      end else begin
         // Stage 1: capture raw word.
         if (s1_ready) begin
            s1_valid <= in_valid_i;
         end
         if (in_valid_i && s1_ready) begin
            s1_data <= one_hot_i;
         end

         // Stage 2: register encoded result; held while downstream stalls.
         if (s2_ready) begin
            out_valid_o <= s1_valid;
         end
         if (s1_valid && s2_ready) begin
            bin_o <= enc_bin;
            err_o <= enc_err;
         end

         // Clear wins over a coincident error handshake; counter never wraps.
         if (err_cnt_clr_i) begin
            err_cnt_o <= '0;
         end else if (err_evt && (err_cnt_o != {ERR_CNT_W{1'b1}})) begin
            err_cnt_o <= err_cnt_o + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule
